sram_burst_ctrl: RTL and testbench

- Parametrised Avalon-MM slave to asynchronous SRAM controller. It is the successor to the fixed 16-bit/19-bit SRAM tristate bridge path in ECE423_QSYS.
- Adds configurable data/address width, programmable read/write wait states, incrementing bursts and byte enables.
- Sits between the system interconnect and the top-level SRAM pins. The top level builds the tristate dq buffer from sram_dq_out/sram_dq_oe/sram_dq_in.

---
 rtl/sram_burst_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_sram_burst_ctrl.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_burst_ctrl.sv
// Avalon-MM slave to asynchronous SRAM: wait states, incrementing bursts, byte enables.
// Define SRAM_TURNAROUND_EN to insert one bus-idle cycle after every read transaction.
module sram_burst_ctrl #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 19,
    parameter int BURST_W    = 4,
    parameter int READ_WAIT  = 1,
    parameter int WRITE_WAIT = 1
) (
    input  logic                  clk_clk,
    input  logic                  reset_reset_n,
    input  logic [ADDR_W-1:0]     avs_address,
    input  logic                  avs_read,
    input  logic                  avs_write,
    input  logic [DATA_W-1:0]     avs_writedata,
    input  logic [DATA_W/8-1:0]   avs_byteenable,
    input  logic [BURST_W-1:0]    avs_burstcount,
    output logic                  avs_waitrequest,
    output logic [DATA_W-1:0]     avs_readdata,
    output logic                  avs_readdatavalid,
    output logic [ADDR_W-1:0]     sram_addr,
    output logic [DATA_W-1:0]     sram_dq_out,
    output logic                  sram_dq_oe,
    input  logic [DATA_W-1:0]     sram_dq_in,
    output logic                  sram_ce_n,
    output logic                  sram_oe_n,
    output logic                  sram_we_n,
    output logic [DATA_W/8-1:0]   sram_be_n,
    output logic                  err_rdwr
);

    localparam int BE_W = DATA_W / 8;
    localparam logic [3:0] RD_LAST = 4'(READ_WAIT);
    localparam logic [3:0] WR_LAST = 4'(WRITE_WAIT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WR_PULSE,
        S_WR_HOLD,
        S_WR_NEXT,
        S_TURN
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [BURST_W-1:0]  beats_q, beats_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [BE_W-1:0]     be_n_q, be_n_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                rvalid_q, rvalid_d;
    logic                err_q, err_d;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            beats_q  <= '0;
            cnt_q    <= '0;
            wdata_q  <= '0;
            be_n_q   <= '1;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            beats_q  <= beats_d;
            cnt_q    <= cnt_d;
            wdata_q  <= wdata_d;
            be_n_q   <= be_n_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        beats_d  = beats_q;
        cnt_d    = cnt_q;
        wdata_d  = wdata_q;
        be_n_d   = be_n_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        err_d    = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (avs_read || avs_write) begin
                    addr_d  = avs_address;
                    beats_d = (avs_burstcount == '0) ? BURST_W'(1)
                                                     : avs_burstcount;
                    cnt_d   = '0;
                end
                // Read wins a collision; the write is dropped and flagged.
                if (avs_read) begin
                    state_d = S_RD;
                    err_d   = err_q | avs_write;
                end else if (avs_write) begin
                    state_d = S_WR_PULSE;
                    wdata_d = avs_writedata;
                    be_n_d  = ~avs_byteenable;
                end
            end
            S_RD: begin
                if (cnt_q == RD_LAST) begin
                    rdata_d  = sram_dq_in;
                    rvalid_d = 1'b1;
                    addr_d   = addr_q + ADDR_W'(1);
                    beats_d  = beats_q - BURST_W'(1);
                    cnt_d    = '0;
                    if (beats_q == BURST_W'(1)) begin
`ifdef SRAM_TURNAROUND_EN
                        state_d = S_TURN;
`else
                        state_d = S_IDLE;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_WR_PULSE: begin
                if (cnt_q == WR_LAST) begin
                    state_d = S_WR_HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_WR_HOLD: begin
                beats_d = beats_q - BURST_W'(1);
                if (beats_q > BURST_W'(1)) begin
                    addr_d  = addr_q + ADDR_W'(1);
                    state_d = S_WR_NEXT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WR_NEXT: begin
                if (avs_write) begin
                    wdata_d = avs_writedata;
                    be_n_d  = ~avs_byteenable;
                    cnt_d   = '0;
                    state_d = S_WR_PULSE;
                end
            end
            S_TURN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        sram_ce_n       = 1'b1;
        sram_oe_n       = 1'b1;
        sram_we_n       = 1'b1;
        sram_be_n       = '1;
        sram_dq_oe      = 1'b0;
        avs_waitrequest = 1'b1;
        unique case (state_q)
            S_IDLE: begin
                avs_waitrequest = 1'b0;
            end
            S_RD: begin
                sram_ce_n = 1'b0;
                sram_oe_n = 1'b0;
                sram_be_n = '0;
            end
            S_WR_PULSE: begin
                sram_ce_n  = 1'b0;
                sram_we_n  = 1'b0;
                sram_be_n  = be_n_q;
                sram_dq_oe = 1'b1;
            end
            // we_n released while address/data stay valid for hold time.
            S_WR_HOLD: begin
                sram_ce_n  = 1'b0;
                sram_be_n  = be_n_q;
                sram_dq_oe = 1'b1;
            end
            S_WR_NEXT: begin
                avs_waitrequest = ~avs_write;
            end
            default: begin
                avs_waitrequest = 1'b1;
            end
        endcase
    end

    assign sram_addr         = addr_q;
    assign sram_dq_out       = wdata_q;
    assign avs_readdata      = rdata_q;
    assign avs_readdatavalid = rvalid_q;
    assign err_rdwr          = err_q;

endmodule

// File: tb/tb_sram_burst_ctrl.sv
// Bench for sram_burst_ctrl: pad-level SRAM model, directed and random bursts.
// Expected memory contents are tracked separately from the pad model.
module tb_sram_burst_ctrl;

    localparam int DW = 16;
    localparam int AW = 19;
    localparam int BW = 4;
    localparam int RW = 1;
    localparam int WW = 1;
`ifdef SRAM_TURNAROUND_EN
    localparam int TURN_GAP = 2;
`else
    localparam int TURN_GAP = 1;
`endif

    logic          clk_clk = 1'b0;
    logic          reset_reset_n = 1'b1;
    logic [AW-1:0] avs_address = '0;
    logic          avs_read = 1'b0;
    logic          avs_write = 1'b0;
    logic [DW-1:0] avs_writedata = '0;
    logic [1:0]    avs_byteenable = '0;
    logic [BW-1:0] avs_burstcount = '0;
    logic          avs_waitrequest;
    logic [DW-1:0] avs_readdata;
    logic          avs_readdatavalid;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_dq_out;
    logic          sram_dq_oe;
    logic [DW-1:0] sram_dq_in;
    logic          sram_ce_n;
    logic          sram_oe_n;
    logic          sram_we_n;
    logic [1:0]    sram_be_n;
    logic          err_rdwr;

    sram_burst_ctrl #(
        .DATA_W(DW), .ADDR_W(AW), .BURST_W(BW),
        .READ_WAIT(RW), .WRITE_WAIT(WW)
    ) dut (
        .clk_clk(clk_clk),
        .reset_reset_n(reset_reset_n),
        .avs_address(avs_address),
        .avs_read(avs_read),
        .avs_write(avs_write),
        .avs_writedata(avs_writedata),
        .avs_byteenable(avs_byteenable),
        .avs_burstcount(avs_burstcount),
        .avs_waitrequest(avs_waitrequest),
        .avs_readdata(avs_readdata),
        .avs_readdatavalid(avs_readdatavalid),
        .sram_addr(sram_addr),
        .sram_dq_out(sram_dq_out),
        .sram_dq_oe(sram_dq_oe),
        .sram_dq_in(sram_dq_in),
        .sram_ce_n(sram_ce_n),
        .sram_oe_n(sram_oe_n),
        .sram_we_n(sram_we_n),
        .sram_be_n(sram_be_n),
        .err_rdwr(err_rdwr)
    );

    always #5 clk_clk = ~clk_clk;

    logic [DW-1:0] pad_mem [256];
    logic [DW-1:0] exp_mem [256];
    assign sram_dq_in = pad_mem[sram_addr[7:0]];

    int n_chk = 0;
    int n_pass = 0;
    int n_fail = 0;

    int cyc = 0;
    int we_len = 0;
    int we_low_total = 0;
    int oe_low_total = 0;
    int viol = 0;
    int oe_rise_cyc = 0;
    int dq_rise_cyc = 0;
    logic prev_oe_n = 1'b1;
    logic prev_dq_oe = 1'b0;
    logic [DW-1:0] rv_q [$];
    int            rv_cyc [$];
    logic [AW-1:0] oa_q [$];
    int            wl_q [$];
    logic [AW-1:0] wa_q [$];
    logic [1:0]    wb_q [$];
    logic [DW-1:0] wd_q [$];

    always @(negedge clk_clk) begin
        cyc++;
        if (avs_readdatavalid) begin
            rv_q.push_back(avs_readdata);
            rv_cyc.push_back(cyc);
        end
        if (!sram_oe_n) begin
            oe_low_total++;
            if (prev_oe_n || oa_q.size() == 0 || oa_q[$] != sram_addr)
                oa_q.push_back(sram_addr);
        end
        if (sram_oe_n && !prev_oe_n) oe_rise_cyc = cyc;
        if (sram_dq_oe && !prev_dq_oe) dq_rise_cyc = cyc;
        if (!sram_we_n) begin
            we_len++;
            we_low_total++;
            if (!sram_ce_n)
                for (int b = 0; b < 2; b++)
                    if (!sram_be_n[b])
                        pad_mem[sram_addr[7:0]][8*b +: 8] = sram_dq_out[8*b +: 8];
        end else if (we_len > 0) begin
            wl_q.push_back(we_len);
            wa_q.push_back(sram_addr);
            wb_q.push_back(sram_be_n);
            wd_q.push_back(sram_dq_out);
            we_len = 0;
        end
        if (!sram_oe_n && !sram_we_n) viol++;
        if (sram_dq_oe && !sram_oe_n) viol++;
        prev_oe_n = sram_oe_n;
        prev_dq_oe = sram_dq_oe;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_clk);
        if (n > 0) #1;
    endtask

    task automatic avs_cmd(input logic rd, input logic wr,
                           input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [1:0] be, input logic [BW-1:0] bc,
                           output int acc);
        int n = 0;
        logic ok = 1'b0;
        avs_read = rd;
        avs_write = wr;
        avs_address = a;
        avs_writedata = d;
        avs_byteenable = be;
        avs_burstcount = bc;
        while (!ok && n < 300) begin
            @(negedge clk_clk);
            ok = !avs_waitrequest;
            @(posedge clk_clk);
            n++;
        end
        acc = cyc;
        #1;
        avs_read = 1'b0;
        avs_write = 1'b0;
        check("accept", 32'(ok), 1);
    endtask

    task automatic wait_rv(input int n);
        int k = 0;
        while (rv_q.size() < n && k < 100) begin
            @(posedge clk_clk);
            k++;
        end
        if (k > 0) #1;
        check("rv_count", rv_q.size(), n);
    endtask

    task automatic model_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                               input logic [1:0] be);
        for (int b = 0; b < 2; b++)
            if (be[b]) exp_mem[a[7:0]][8*b +: 8] = d[8*b +: 8];
    endtask

    task automatic clear_mon();
        rv_q.delete();
        rv_cyc.delete();
        oa_q.delete();
        wl_q.delete();
        wa_q.delete();
        wb_q.delete();
        wd_q.delete();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    int acc;
    int len;
    int gap;
    logic bad;
    logic [AW-1:0] a;
    logic [AW-1:0] ea;
    logic [DW-1:0] d;
    logic [1:0] be;
    logic [BW-1:0] bc;

    initial begin
        for (int i = 0; i < 256; i++) begin
            d = DW'($urandom);
            pad_mem[i] = d;
            exp_mem[i] = d;
        end
        reset_reset_n = 1'b0;
        repeat (3) @(posedge clk_clk);
        #1 reset_reset_n = 1'b1;
        @(negedge clk_clk);
        check("rst_ctl_n", {sram_ce_n, sram_oe_n, sram_we_n}, 3'b111);
        check("rst_be_n", sram_be_n, 2'b11);
        check("rst_dq_oe", sram_dq_oe, 0);
        check("rst_addr", sram_addr, 0);
        check("rst_dq_out", sram_dq_out, 0);
        check("rst_rdata", avs_readdata, 0);
        check("rst_rvalid", avs_readdatavalid, 0);
        check("rst_err", err_rdwr, 0);
        check("rst_waitreq", avs_waitrequest, 0);
        @(posedge clk_clk);
        #1;

        pad_mem[8'h10] = 16'hBEEF;
        exp_mem[8'h10] = 16'hBEEF;
        clear_mon();
        oe_low_total = 0;
        avs_cmd(1'b1, 1'b0, 19'h00010, '0, '0, 4'd1, acc);
        wait_rv(1);
        check("single_rdata", rv_q[0], exp_mem[8'h10]);
        check("single_latency", rv_cyc[0] - acc - 1, RW + 1);
        idle(2);
        check("single_oe_len", oe_low_total, RW + 1);

        clear_mon();
        avs_cmd(1'b1, 1'b0, 19'h7FFFE, '0, '0, 4'd4, acc);
        wait_rv(4);
        check("burst_naddr", oa_q.size(), 4);
        for (int k = 0; k < 4; k++) begin
            ea = 19'h7FFFE + AW'(k);
            check("burst_addr", oa_q[k], ea);
            check("burst_rdata", rv_q[k], exp_mem[ea[7:0]]);
            if (k > 0) check("burst_space", rv_cyc[k] - rv_cyc[k-1], RW + 1);
        end

        clear_mon();
        a = 19'h00040;
        avs_cmd(1'b0, 1'b1, a, 16'h1234, 2'b01, 4'd2, acc);
        model_write(a, 16'h1234, 2'b01);
        idle(4);
        bad = 1'b0;
        repeat (5) begin
            @(negedge clk_clk);
            if (sram_ce_n !== 1'b1 || sram_dq_oe !== 1'b0 || avs_waitrequest !== 1'b1)
                bad = 1'b1;
        end
        @(posedge clk_clk);
        #1;
        check("wrnext_idle", bad, 0);
        avs_cmd(1'b0, 1'b1, 19'h01555, 16'hABCD, 2'b11, 4'd7, acc);
        model_write(a + AW'(1), 16'hABCD, 2'b11);
        idle(5);
        check("wr_npulse", wl_q.size(), 2);
        check("wr_len0", wl_q[0], WW + 1);
        check("wr_len1", wl_q[1], WW + 1);
        check("wr_be0", wb_q[0], 2'b10);
        check("wr_be1", wb_q[1], 2'b00);
        check("wr_addr0", wa_q[0], a);
        check("wr_addr1", wa_q[1], a + AW'(1));
        check("wr_data0", wd_q[0], 16'h1234);
        check("wr_data1", wd_q[1], 16'hABCD);
        clear_mon();
        avs_cmd(1'b1, 1'b0, a, '0, '0, 4'd2, acc);
        wait_rv(2);
        check("wr_rb0", rv_q[0], exp_mem[8'h40]);
        check("wr_rb1", rv_q[1], exp_mem[8'h41]);

        clear_mon();
        we_low_total = 0;
        avs_cmd(1'b1, 1'b1, 19'h00050, 16'hDEAD, 2'b11, 4'd1, acc);
        wait_rv(1);
        check("rdwr_rdata", rv_q[0], exp_mem[8'h50]);
        idle(3);
        check("rdwr_no_we", we_low_total, 0);
        check("rdwr_err", err_rdwr, 1);
        clear_mon();
        avs_cmd(1'b1, 1'b0, 19'h00051, '0, '0, 4'd1, acc);
        wait_rv(1);
        check("rdwr_err_sticky", err_rdwr, 1);

        clear_mon();
        oe_rise_cyc = 0;
        dq_rise_cyc = 0;
        avs_cmd(1'b1, 1'b0, 19'h00060, '0, '0, 4'd1, acc);
        avs_cmd(1'b0, 1'b1, 19'h00061, 16'h5A5A, 2'b11, 4'd1, acc);
        model_write(19'h00061, 16'h5A5A, 2'b11);
        idle(6);
        check("turn_gap", dq_rise_cyc - oe_rise_cyc, TURN_GAP);

        for (int it = 0; it < 24; it++) begin
            len = $urandom_range(1, 4);
            a = AW'($urandom_range(8'h80, 8'hF0));
            if ($urandom_range(0, 1) == 1) begin
                for (int b = 0; b < len; b++) begin
                    d = DW'($urandom);
                    be = 2'($urandom_range(0, 3));
                    if (b == 0) begin
                        bc = (len == 1 && $urandom_range(0, 1) == 1) ? '0 : BW'(len);
                        avs_cmd(1'b0, 1'b1, a, d, be, bc, acc);
                    end else begin
                        gap = $urandom_range(0, 3);
                        idle(gap);
                        avs_cmd(1'b0, 1'b1, AW'($urandom), d, be, BW'($urandom), acc);
                    end
                    model_write(a + AW'(b), d, be);
                end
            end else begin
                clear_mon();
                bc = (len == 1 && $urandom_range(0, 1) == 1) ? '0 : BW'(len);
                avs_cmd(1'b1, 1'b0, a, '0, '0, bc, acc);
                wait_rv(len);
                for (int k = 0; k < len; k++) begin
                    ea = a + AW'(k);
                    check("rand_rdata", rv_q[k], exp_mem[ea[7:0]]);
                end
            end
        end

        clear_mon();
        avs_cmd(1'b1, 1'b0, 19'h00090, '0, '0, 4'd4, acc);
        idle(2);
        #2 reset_reset_n = 1'b0;
        #1;
        check("rst_async_ctl", {sram_ce_n, sram_oe_n}, 2'b11);
        clear_mon();
        repeat (2) @(posedge clk_clk);
        #1 reset_reset_n = 1'b1;
        idle(10);
        check("rst_no_rvalid", rv_q.size(), 0);
        check("rst_err_clr", err_rdwr, 0);
        check("rst_rdata_clr", avs_readdata, 0);
        check("invariants", viol, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
